// File: rtl/seq_detect_pkg.sv
// Shared constants for the parametrised serial sequence detector family.
package seq_detect_pkg;

    localparam int PATTERN_LEN_MAX = 16;
    localparam int FILL_W          = $clog2(PATTERN_LEN_MAX);

    // Patterns are right-aligned; MSB of the used width is the first bit received.
    localparam logic [PATTERN_LEN_MAX-1:0] PAT_1011 = 16'b0000_0000_0000_1011;
    localparam logic [PATTERN_LEN_MAX-1:0] PAT_0001 = 16'b0000_0000_0000_0001;

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial-stream bus into the detector and its match/status outputs.
// w is consumed on a clock edge only when w_valid=1; there is no back-pressure.
interface seq_detect_param_if
    import seq_detect_pkg::*;
#(
    parameter int COUNT_W = 8
);

    logic               w;
    logic               w_valid;
    logic               overlap;
    logic               clr;
    logic               z_mealy;
    logic               z_moore;
    logic [COUNT_W-1:0] match_count;
    logic [FILL_W-1:0]  dbg_fill;

    modport master (
        output w, w_valid, overlap, clr,
        input  z_mealy, z_moore, match_count, dbg_fill
    );

    modport slave (
        input  w, w_valid, overlap, clr,
        output z_mealy, z_moore, match_count, dbg_fill
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// Detects a PATTERN_LEN-bit pattern on a qualified serial stream, with
// overlapping/non-overlapping modes, Mealy and Moore flags and a match counter.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                          PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN_MAX-1:0]  PATTERN     = PAT_1011,
    parameter int                          COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_detect_param_if.slave  bus
);

    localparam int                      HIST_W    = PATTERN_LEN - 1;
    localparam logic [FILL_W-1:0]       FILL_FULL = FILL_W'(PATTERN_LEN - 1);
    localparam logic [PATTERN_LEN-1:0]  PAT       = PATTERN[PATTERN_LEN-1:0];

    generate
        if (PATTERN_LEN < 2 || PATTERN_LEN > PATTERN_LEN_MAX) begin : g_bad_len
            $error("seq_detect_param: PATTERN_LEN must be in 2..16");
        end
        if ((PATTERN >> PATTERN_LEN) != '0) begin : g_bad_pattern
            $error("seq_detect_param: PATTERN has bits above PATTERN_LEN");
        end
    endgenerate

    logic [HIST_W-1:0]      hist_q, hist_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic                   z_moore_q, z_moore_d;
    logic [PATTERN_LEN-1:0] window;
    logic                   match_raw;
    logic [COUNT_W-1:0]     count;

    // The window is the stored history plus the bit arriving this cycle.
    assign window    = {hist_q, bus.w};
    assign match_raw = bus.w_valid & ~bus.clr & (fill_q == FILL_FULL) & (window == PAT);

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        z_moore_d = match_raw;
        if (bus.clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bus.w_valid) begin
            if (match_raw && !bus.overlap) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[HIST_W-1:0];
                fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q    <= '0;
            fill_q    <= '0;
            z_moore_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            z_moore_q <= z_moore_d;
        end
    end

    sat_counter #(
        .W (COUNT_W)
    ) u_match_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (match_raw),
        .count (count)
    );

    assign bus.z_mealy     = match_raw;
    assign bus.z_moore     = z_moore_q;
    assign bus.match_count = count;
    assign bus.dbg_fill    = fill_q;

endmodule
